// File: rtl/barrel_shift_pipe.sv
// barrel_shift_pipe -- 3-stage pipelined barrel shifter with valid/ready flow control.
//
// Modes: 00 SLL, 01 SRL, 10 SRA, 11 ROL. Shift amount is unsigned, SW bits wide.
//   S1 registers the beat, S2 applies amount bits SW-1..SW/2, S3 applies the
//   remaining bits and resolves the flags into the output registers.
// The whole pipe advances on a single enable (en = !out_valid | out_ready);
// bubbles are not squeezed out.
//
// Ports
//   clk, rst_n        clock, async active-low reset
//   in_valid/in_ready input handshake (in_ready == en)
//   in_data           operand [WIDTH]
//   in_shamt          shift amount [SW]
//   in_mode           operation select [2]
//   out_valid/out_ready output handshake
//   out_data          result [WIDTH]
//   out_ovf           SLL: a 1 bit left the top
//   out_sticky        SRL/SRA: OR of all bits that left the bottom
module barrel_shift_pipe #(
  parameter int WIDTH = 24,
  parameter int SW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [SW-1:0]    in_shamt,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_sticky
);

  localparam int STAGES = 3;
  // Amount bits at or above SPLIT are handled in S2, the rest in S3.
  localparam int SPLIT  = SW / 2;

  localparam logic [1:0] M_SLL = 2'b00;
  localparam logic [1:0] M_SRL = 2'b01;
  localparam logic [1:0] M_SRA = 2'b10;

  if ((WIDTH < 2) || (WIDTH > 64)) begin : g_bad_width
    $error("barrel_shift_pipe: WIDTH=%0d outside 2..64", WIDTH);
  end
  if (SW != $clog2(WIDTH)) begin : g_bad_sw
    $error("barrel_shift_pipe: SW=%0d must equal clog2(WIDTH)=%0d", SW, $clog2(WIDTH));
  end

  // A beat in flight. 'lost' accumulates the OR of every bit pushed off
  // either end so far; it becomes ovf or sticky depending on mode at the end.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SW-1:0]    shamt;
    logic [1:0]       mode;
    logic             lost;
  } beat_t;

  // One power-of-two shift level, k < WIDTH. Returns {lost_bits_or, result}.
  // Because every level amount is below WIDTH, chaining levels gives the exact
  // total: oversize shifts drop everything, and rotations compose modulo WIDTH
  // so ROL needs no explicit modulo even for non-power-of-two WIDTH.
  function automatic logic [WIDTH:0] lvl(input logic [WIDTH-1:0] d,
                                         input logic [1:0]       m,
                                         input int               k);
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic [WIDTH-1:0] res;
    logic             lost;
    hi_out = d >> (WIDTH - k);  // top k bits, leaving on a left shift
    lo_out = d << (WIDTH - k);  // bottom k bits, leaving on a right shift
    case (m)
      M_SLL: begin res = d << k;                        lost = |hi_out; end
      M_SRL: begin res = d >> k;                        lost = |lo_out; end
      M_SRA: begin res = $unsigned($signed(d) >>> k);   lost = |lo_out; end
      default: begin res = (d << k) | (d >> (WIDTH - k)); lost = 1'b0; end
    endcase
    return {lost, res};
  endfunction

  logic                en;
  logic [STAGES:1]     vld_pipe;
  beat_t               s1_q, s2_q, s2_d;
  logic [WIDTH:0]      r2, r3;
  logic [WIDTH-1:0]    s3_data;
  logic                s3_lost;
  logic                unused_s2_shamt;

  assign en        = !out_valid | out_ready;
  assign in_ready  = en;
  assign out_valid = vld_pipe[STAGES];

  // S2 combinational: upper amount bits.
  always_comb begin
    s2_d = s1_q;
    r2   = '0;
    for (int i = SW - 1; i >= SPLIT; i--) begin
      if (s1_q.shamt[i]) begin
        r2        = lvl(s2_d.data, s2_d.mode, 1 << i);
        s2_d.data = r2[WIDTH-1:0];
        s2_d.lost = s2_d.lost | r2[WIDTH];
      end
    end
  end

  // S3 combinational: lower amount bits.
  always_comb begin
    s3_data = s2_q.data;
    s3_lost = s2_q.lost;
    r3      = '0;
    for (int i = SPLIT - 1; i >= 0; i--) begin
      if (s2_q.shamt[i]) begin
        r3      = lvl(s3_data, s2_q.mode, 1 << i);
        s3_data = r3[WIDTH-1:0];
        s3_lost = s3_lost | r3[WIDTH];
      end
    end
  end

  // Upper amount bits were consumed in S2.
  assign unused_s2_shamt = ^s2_q.shamt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe   <= '0;
      s1_q       <= '0;
      s2_q       <= '0;
      out_data   <= '0;
      out_ovf    <= 1'b0;
      out_sticky <= 1'b0;
    end else if (en) begin
      vld_pipe   <= {vld_pipe[STAGES-1:1], in_valid};
      s1_q       <= '{data: in_data, shamt: in_shamt, mode: in_mode, lost: 1'b0};
      s2_q       <= s2_d;
      out_data   <= s3_data;
      out_ovf    <= s3_lost & (s2_q.mode == M_SLL);
      out_sticky <= s3_lost & ((s2_q.mode == M_SRL) | (s2_q.mode == M_SRA));
    end
  end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
module tb_barrel_shift_pipe;

  localparam int W = 24;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [4:0]    in_shamt;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic          out_ovf;
  logic          out_sticky;

  barrel_shift_pipe #(.WIDTH(W), .SW(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_shamt(in_shamt), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ovf(out_ovf), .out_sticky(out_sticky)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] d;
    logic         ovf;
    logic         st;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   acc_cyc = 0;
  int   out_cnt = 0;
  int   out_cyc = 0;
  int   ready_mode = 0;  // 0 always ready, 1 held low, 2 random
  bit   bp_done;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Reference model: wide shifts so no bit is lost before it is observed.
  function automatic exp_t model(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] m);
    exp_t               e;
    logic [127:0]       f;
    logic signed [127:0] s;
    logic [2*W-1:0]     t;
    int                 r;
    e.d = '0; e.ovf = 1'b0; e.st = 1'b0;
    case (m)
      2'b00: begin f = 128'(d) << sh; e.d = f[W-1:0]; e.ovf = |f[127:W]; end
      2'b01: begin f = {40'b0, d, 64'b0} >> sh; e.d = f[64+W-1:64]; e.st = |f[63:0]; end
      2'b10: begin
        s = {{40{d[W-1]}}, d, 64'b0};
        s = s >>> sh;
        e.d = s[64+W-1:64]; e.st = |s[63:0];
      end
      default: begin r = int'(sh) % W; t = {d, d} << r; e.d = t[2*W-1:W]; end
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0: out_ready = 1'b1;
      1: out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Output monitor: every visible result is compared against the scoreboard
  // head; while stalled the same head is re-checked, so held outputs must match.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (sb.size() == 0) chk("spurious_out", out_valid, 1'b0);
      else if (out_ready) begin
        chk("out", {out_data, out_ovf, out_sticky}, {sb[0].d, sb[0].ovf, sb[0].st});
        sb.delete(0);
        out_cnt++;
        out_cyc = cyc;
      end else begin
        chk("stall_hold", {out_data, out_ovf, out_sticky}, {sb[0].d, sb[0].ovf, sb[0].st});
      end
    end
  end

  // Entered and left at posedge+1.
  task automatic send(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] m, input exp_t e);
    int t;
    bit done;
    t = 0; done = 0;
    in_valid = 1'b1; in_data = d; in_shamt = sh; in_mode = m;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back(e); acc_cnt++; acc_cyc = cyc; done = 1;
      end else begin
        t++;
        if (t > 300) begin chk("accept_timeout", in_ready, 1'b1); done = 1; end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic sendm(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] m);
    send(d, sh, m, model(d, sh, m));
  endtask

  task automatic sendx(input logic [W-1:0] d, input logic [4:0] sh, input logic [1:0] m,
                       input logic [W-1:0] ed, input logic eo, input logic es);
    exp_t e;
    e.d = ed; e.ovf = eo; e.st = es;
    send(d, sh, m, e);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin @(posedge clk); #1; t++; end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    int base;
    int t;
    logic [W-1:0] rd;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_mode = '0;
    out_ready = 1'b1;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 0);
    chk("rst_flags", {out_ovf, out_sticky}, 2'b00);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;

    // Directed vectors with hand-derived results.
    sendx(24'h000001, 5'd23, 2'b00, 24'h800000, 1'b0, 1'b0);
    sendx(24'h000001, 5'd24, 2'b00, 24'h000000, 1'b1, 1'b0);
    sendx(24'hC00000, 5'd1,  2'b00, 24'h800000, 1'b1, 1'b0);
    sendx(24'h800000, 5'd4,  2'b10, 24'hF80000, 1'b0, 1'b0);
    sendx(24'h80000F, 5'd4,  2'b10, 24'hF80000, 1'b0, 1'b1);
    sendx(24'h80000F, 5'd31, 2'b01, 24'h000000, 1'b0, 1'b1);
    sendx(24'h800001, 5'd1,  2'b11, 24'h000003, 1'b0, 1'b0);
    sendx(24'h800001, 5'd25, 2'b11, 24'h000003, 1'b0, 1'b0);
    sendx(24'h123456, 5'd0,  2'b11, 24'h123456, 1'b0, 1'b0);
    sendx(24'hFFFFFF, 5'd0,  2'b00, 24'hFFFFFF, 1'b0, 1'b0);
    sendx(24'h800000, 5'd31, 2'b10, 24'hFFFFFF, 1'b0, 1'b1);
    drain();
    chk("directed_count", out_cnt, 11);

    // Backpressure: out_ready low before any beat is offered.
    ready_mode = 1;
    repeat (2) begin @(posedge clk); #1; end
    acc_cnt = 0; bp_done = 0; base = out_cnt;
    fork
      begin
        for (int i = 0; i < 4; i++)
          sendm(24'h0A5A5A ^ (24'h111111 * 24'(i)), 5'(3 * i + 2), 2'(i));
        bp_done = 1;
      end
    join_none
    repeat (8) begin @(posedge clk); #1; end
    chk("bp_accepted", acc_cnt, 3);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_out_valid", out_valid, 1'b1);
    ready_mode = 0;
    t = 0;
    while (!bp_done && t < 300) begin @(posedge clk); #1; t++; end
    chk("bp_sender_done", bp_done, 1'b1);
    drain();
    chk("bp_out_count", out_cnt - base, 4);

    // Random mixed modes, out_ready toggling.
    ready_mode = 2;
    for (int i = 0; i < 80; i++) begin
      rd = W'($urandom);
      sendm(rd, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)));
    end
    ready_mode = 0;
    drain();

    // Reset with two beats in flight, one already on the output.
    sendm(24'h00F00F, 5'd3, 2'b00);
    sendm(24'h90F00F, 5'd7, 2'b10);
    @(posedge clk); #1;
    chk("pre_rst_out_valid", out_valid, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", {out_data, out_ovf, out_sticky}, 0);
    chk("midrst_in_ready", in_ready, 1'b1);
    in_valid = 1'b1; in_data = 24'hABCDEF; in_shamt = 5'd1; in_mode = 2'b00;
    repeat (2) @(posedge clk);
    #1; in_valid = 1'b0; rst_n = 1'b1;
    base = out_cnt;
    sendm(24'h345678, 5'd9, 2'b11);
    drain();
    repeat (4) begin @(posedge clk); #1; end
    chk("post_rst_outs", out_cnt - base, 1);
    chk("post_rst_latency", out_cyc - acc_cyc, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
